serial_subtractor_ctrl: RTL
===========================

// Module: serial_subtractor_ctrl
// PURPOSE
//  Bit-serial N-bit subtractor: computes a - b - bin by feeding one bit per clock,
//  LSB first, through a single full-subtractor slice with a registered borrow.
//  A small FSM handles operand capture, shift sequencing and the start/done handshake.
//  Used where area matters more than latency in front of the adder/subtractor datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      request; sampled only in IDLE or DONE
//  a       in   WIDTH  minuend; captured on the accepting edge
//  b       in   WIDTH  subtrahend; captured on the accepting edge
//  bin     in   1      borrow-in; seeds the borrow register on the accepting edge
//  busy    out  1      1 while in SHIFT
//  done    out  1      1-cycle pulse; diff/bout (and ovf) are valid from this cycle on
//  diff    out  WIDTH  result a - b - bin, modulo 2^WIDTH
//  bout    out  1      borrow-out of the MSB (1 = unsigned a < b + bin)
//  ovf     out  1      signed overflow; present only when SERIAL_SUB_OVF_EN is defined
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0,
//    bit counter=0, borrow reg=0, shift regs=0. Any in-flight operation is discarded.
//  - Bit slice, per cycle, on current LSBs x, y and borrow c:
//    d = x^y^c; c_next = (~x&y) | (~x&c) | (y&c).
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE: start=1 -> load a/b into shift regs, borrow<=bin, cnt<=0, go SHIFT.
//    SHIFT: each edge consumes one bit. Shift a/b right, shift d into the result MSB,
//      borrow<=c_next, cnt<=cnt+1. start is ignored. On the edge with cnt==WIDTH-1,
//      write diff<=final result and bout<=c_next, then go DONE.
//    DONE: done=1 for exactly one cycle.
//      start=1 -> same load as IDLE, go SHIFT (back-to-back).
//      start=0 -> go IDLE.
//  - Latency: start is accepted at edge T. diff, bout and done become valid after
//    edge T+WIDTH. Issue interval is WIDTH+1 cycles.
//  - diff/bout change only on entry to DONE. They hold their values through IDLE and
//    through the next SHIFT until that operation completes.
//  - busy=1 only in SHIFT. busy and done are never both high.
//  - Counter width is $clog2(WIDTH). It wraps only via reload, never by overflow.
//  - a, b and bin are don't-care except on the accepting edge. Changing them during
//    SHIFT has no effect.
//  - start held high continuously: a new operation starts every WIDTH+1 cycles, each
//    time from DONE.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined:
//    - Port ovf exists. On the edge with cnt==WIDTH-1, ovf <= c_in_msb ^ c_next, where
//      c_in_msb is the borrow into the MSB (signed two's-complement overflow).
//    - ovf is valid and held on the same schedule as bout. Reset value is 0.
//  SERIAL_SUB_OVF_EN undefined:
//    - No ovf port and no ovf logic. All other behaviour is identical.
// TESTING
//  1. WIDTH=8: a=8'h05, b=8'h03, bin=0, start at T -> done pulse after T+8,
//     diff=8'h02, bout=0; busy high for exactly 8 cycles.
//  2. a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Then a=8'h10, b=8'h0F, bin=1
//     -> diff=8'h00, bout=0.
//  3. OVF_EN: a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1, bout=0; a=8'h7F, b=8'hFF
//     -> diff=8'h80, ovf=1, bout=1. Without OVF_EN, same diff/bout.
//  4. Pulse start with new operands mid-SHIFT, and change a/b every cycle during SHIFT
//     -> ignored; the result matches the operands captured at acceptance.
//  5. Assert rst 3 cycles into SHIFT -> all outputs 0 immediately. No done pulse.
//     The next start completes normally.
//  6. start held high across 3 ops -> done pulses exactly WIDTH+1 cycles apart.
//     Each diff is correct. A random sweep of 1000 ops matches a reference model.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), one bit per clock LSB first, with start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               brw_q, brw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // Full-subtractor slice on the current LSBs and the registered borrow.
    logic slice_x, slice_y, slice_d, slice_c_next;

    always_comb begin
        slice_x      = a_q[0];
        slice_y      = b_q[0];
        slice_d      = slice_x ^ slice_y ^ brw_q;
        slice_c_next = (~slice_x & slice_y) | (~slice_x & brw_q) | (slice_y & brw_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {slice_d, res_q[WIDTH-1:1]};
                brw_d = slice_c_next;
                if (cnt_q == LAST_BIT) begin
                    // Counter holds here; the next load resets it, so it never overflows.
                    diff_d  = {slice_d, res_q[WIDTH-1:1]};
                    bout_d  = slice_c_next;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = brw_q ^ slice_c_next;
`endif
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
